rs_enc: RTL and testbench
=========================

RS_ENC -- requirements
Module: rs_enc

Interface
REQ-001 The module SHALL have no parameters; the code is fixed at RS(204,188), t=8, over GF(256).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 CE  input  1  chip enable, high for one clk per byte slot; consecutive pulses SHALL be at least 2 clks apart.
REQ-005 input_byte  input  8  message byte, sampled on a CE cycle while ready is high.
REQ-006 Out_byte  output  8  codeword byte, valid while CEO is high.
REQ-007 CEO  output  1  one-clk strobe marking each output byte.
REQ-008 Valid_out  output  1  high while a codeword is being emitted.
REQ-009 ready  output  1  high while message bytes are accepted; low during parity slots.

Function
REQ-010 Field SHALL use primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), alpha=0x02; generator g(x)=prod_{i=0..15}(x+alpha^i).
REQ-011 Encoding SHALL be systematic: 188 message bytes output unchanged, then 16 parity bytes, highest-degree parity first.
REQ-012 Parity SHALL use a 16-stage byte LFSR p[0..15]: fb=input_byte^p[15]; p[0]<=fb*g0; p[i]<=p[i-1]^fb*gi; multipliers are constant GF(256) multipliers.
REQ-013 FSM states SHALL be DATA and PARITY; reset enters DATA with data counter 0 and ready=1.
REQ-014 In DATA, each CE SHALL load input_byte into the LFSR, drive Out_byte=input_byte, and increment the data counter (0..187).
REQ-015 On the CE carrying message byte 187, the FSM SHALL go to PARITY, ready SHALL go low the next clk, and the parity counter SHALL clear.
REQ-016 In PARITY, each CE SHALL output p[15], shift the LFSR with fb forced to 0, ignore input_byte, and increment the parity counter (0..15).
REQ-017 On the CE of parity byte 15, the FSM SHALL return to DATA, clear the LFSR and data counter, and raise ready the next clk.
REQ-018 Latency SHALL be exactly 1 clk: CEO and Out_byte register in the clk after each CE; CEO SHALL be low on all other clks.
REQ-019 Out_byte SHALL hold its last value between CEO strobes.
REQ-020 Valid_out SHALL rise with the CEO of message byte 0 and fall the clk after the CEO of parity byte 15.
REQ-021 A CE with reset low SHALL be ignored; no CE is ever dropped in DATA or PARITY.
REQ-022 Blocks SHALL be back-to-back: the CE after parity byte 15 SHALL be message byte 0 of the next block, with no idle slot required.

Reset
REQ-023 While reset is low: Out_byte=0x00, CEO=0, Valid_out=0, ready=1, LFSR=0, counters=0, state=DATA.
REQ-024 Reset asserted mid-block SHALL abandon the partial codeword; no parity SHALL be emitted for it.

Configuration
REQ-025 With macro RS_ENC_ERR_INJECT_EN defined, the module SHALL add input err_mask[7:0]; Out_byte SHALL equal the coded byte XOR err_mask sampled on the CE cycle, and the LFSR SHALL use the uncorrupted byte.
REQ-026 Without RS_ENC_ERR_INJECT_EN, the err_mask port SHALL not exist and Out_byte SHALL be the uncorrupted codeword.

Verification
REQ-027 188 bytes of 0x00 -> 204 CEO strobes, all Out_byte=0x00; Valid_out high for exactly the span of those 204 strobes.
REQ-028 Bytes 0..186=0x00 and byte 187=0x01 -> parity bytes 0..15 equal g15..g0 (generator coefficients excluding the leading 1).
REQ-029 100 random blocks, CE every 8 clks -> every 204-byte codeword matches a software RS(204,188) model, and the reference decoder reports 0 errors.
REQ-030 Reset pulsed low after message byte 100 -> outputs return to reset values; the next 188 bytes yield a correct codeword with no stale parity.
REQ-031 CE pulses during PARITY with input_byte=0xFF -> parity is unchanged from the 0x00-input case; ready is low for exactly 16 CE slots.
REQ-032 RS_ENC_ERR_INJECT_EN defined, err_mask=0x01 on 8 bytes of a codeword -> decoder corrects all 8; on 9 bytes -> decoder flags an uncorrectable block.

Source files
------------

// File: rtl/rs_enc.sv
// ============================================================================
// Module   : rs_enc
// Purpose  : Systematic RS(204,188) encoder, t=8, over GF(256).
//            Field polynomial 0x11D, alpha = 0x02, g(x) = prod_{i=0..15}(x+alpha^i).
//            188 message bytes pass through unchanged and are followed by
//            16 parity bytes, highest-degree parity first.
// Options  : define RS_ENC_ERR_INJECT_EN to add the err_mask input. The mask
//            is XORed onto every emitted byte; the parity LFSR always sees
//            the clean byte.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_enc (
  input  logic       clk,
  input  logic       reset,
  input  logic       CE,
  input  logic [7:0] input_byte,
`ifdef RS_ENC_ERR_INJECT_EN
  input  logic [7:0] err_mask,
`endif
  output logic [7:0] Out_byte,
  output logic       CEO,
  output logic       Valid_out,
  output logic       ready
);

  localparam logic [0:0] ST_DATA   = 1'b0;
  localparam logic [0:0] ST_PARITY = 1'b1;

  localparam logic [7:0] C_LAST_DATA = 8'd187;
  localparam logic [3:0] C_LAST_PAR  = 4'd15;

  // GF(256) multiply, reduction by x^8+x^4+x^3+x^2+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] aa;
    logic [7:0] r;
    aa = a;
    r  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1D : 8'h00);
    end
    return r;
  endfunction

  // Builds g(x) by multiplying in one (x + alpha^i) factor at a time.
  // Coefficient k sits in bits [8k+7:8k]; the monic x^16 term is dropped.
  function automatic logic [127:0] gen_poly();
    logic [7:0]   c [0:16];
    logic [7:0]   root;
    logic [127:0] r;
    for (int k = 0; k <= 16; k++) c[k] = 8'h00;
    c[0] = 8'h01;
    root = 8'h01;
    for (int i = 0; i < 16; i++) begin
      for (int k = 16; k >= 1; k--) c[k] = gf_mul(c[k], root) ^ c[k-1];
      c[0] = gf_mul(c[0], root);
      root = gf_mul(root, 8'h02);
    end
    r = '0;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = c[k];
    return r;
  endfunction

  localparam logic [127:0] C_GEN = gen_poly();

  logic [0:0] state_q, state_d;
  logic [7:0] dcnt_q,  dcnt_d;
  logic [3:0] pcnt_q,  pcnt_d;
  logic [7:0] p_q [16];
  logic [7:0] p_d [16];
  logic [7:0] out_q,   out_d;
  logic       ceo_q,   ceo_d;
  logic       valid_q, valid_d;
  logic       last_q,  last_d;
  logic [7:0] fb;
  logic [7:0] mask;

`ifdef RS_ENC_ERR_INJECT_EN
  assign mask = err_mask;
`else
  assign mask = 8'h00;
`endif

  // Feedback into the LFSR always uses the clean message byte.
  assign fb = input_byte ^ p_q[15];

  // Next-state logic: byte slot handling for DATA and PARITY phases.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    pcnt_d  = pcnt_q;
    out_d   = out_q;
    ceo_d   = 1'b0;
    valid_d = valid_q;
    last_d  = 1'b0;
    for (int i = 0; i < 16; i++) p_d[i] = p_q[i];

    if (CE) begin
      ceo_d   = 1'b1;
      valid_d = 1'b1;
      if (state_q == ST_DATA) begin
        out_d  = input_byte ^ mask;
        p_d[0] = gf_mul(fb, C_GEN[7:0]);
        for (int i = 1; i < 16; i++) p_d[i] = p_q[i-1] ^ gf_mul(fb, C_GEN[8*i +: 8]);
        if (dcnt_q == C_LAST_DATA) begin
          state_d = ST_PARITY;
          dcnt_d  = 8'd0;
          pcnt_d  = 4'd0;
        end else begin
          dcnt_d = dcnt_q + 8'd1;
        end
      end else begin
        // Parity phase: emit the top stage and shift with zero feedback.
        out_d  = p_q[15] ^ mask;
        p_d[0] = 8'h00;
        for (int i = 1; i < 16; i++) p_d[i] = p_q[i-1];
        if (pcnt_q == C_LAST_PAR) begin
          state_d = ST_DATA;
          pcnt_d  = 4'd0;
          dcnt_d  = 8'd0;
          last_d  = 1'b1;
          for (int i = 0; i < 16; i++) p_d[i] = 8'h00;
        end else begin
          pcnt_d = pcnt_q + 4'd1;
        end
      end
    end else if (last_q) begin
      // Drop Valid_out the clk after the final parity strobe.
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_DATA;
      dcnt_q  <= 8'd0;
      pcnt_q  <= 4'd0;
      out_q   <= 8'h00;
      ceo_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      for (int i = 0; i < 16; i++) p_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      pcnt_q  <= pcnt_d;
      out_q   <= out_d;
      ceo_q   <= ceo_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      for (int i = 0; i < 16; i++) p_q[i] <= p_d[i];
    end
  end

  assign Out_byte  = out_q;
  assign CEO       = ceo_q;
  assign Valid_out = valid_q;
  assign ready     = (state_q == ST_DATA);

endmodule

`default_nettype wire

// File: tb/tb_rs_enc.sv
// ============================================================================
// Module   : tb_rs_enc
// Purpose  : Directed self-checking bench for rs_enc (RS(204,188) encoder).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rs_enc;

  logic       clk;
  logic       reset;
  logic       CE;
  logic [7:0] input_byte;
  logic [7:0] Out_byte;
  logic       CEO;
  logic       Valid_out;
  logic       ready;
`ifdef RS_ENC_ERR_INJECT_EN
  logic [7:0] err_mask;
  assign err_mask = 8'h00;
`endif

  rs_enc dut (
    .clk        (clk),
    .reset      (reset),
    .CE         (CE),
    .input_byte (input_byte),
`ifdef RS_ENC_ERR_INJECT_EN
    .err_mask   (err_mask),
`endif
    .Out_byte   (Out_byte),
    .CEO        (CEO),
    .Valid_out  (Valid_out),
    .ready      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: cumulative logs only, bench takes snapshots.
  logic [7:0] outq [$];
  int         ceo_cyc [$];
  int         cyc      = 0;
  int         vcnt     = 0;
  int         hold_err = 0;
  logic [7:0] last_out = 8'h00;

  always @(negedge clk) begin
    cyc++;
    if (Valid_out === 1'b1) vcnt++;
    if (CEO === 1'b1) begin
      outq.push_back(Out_byte);
      ceo_cyc.push_back(cyc);
      last_out = Out_byte;
    end else if (reset !== 1'b1) begin
      last_out = Out_byte;
    end else if (Out_byte !== last_out) begin
      hold_err++;
    end
  end

  // Field multiply, MSB-first Horner form.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1D : 8'h00);
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  // OR of the 16 syndromes c(alpha^j), j=0..15, of the codeword at outq[base].
  function automatic logic [7:0] synd_or(input int base);
    logic [7:0] acc;
    logic [7:0] root;
    logic [7:0] s;
    acc  = 8'h00;
    root = 8'h01;
    for (int j = 0; j < 16; j++) begin
      s = 8'h00;
      for (int k = 0; k < 204; k++) s = gmul(s, root) ^ outq[base + k];
      acc  = acc | s;
      root = gmul(root, 8'h02);
    end
    return acc;
  endfunction

  logic [7:0] msg [188];

  task automatic send_byte(input logic [7:0] b, input int gap);
    input_byte = b;
    CE = 1'b1;
    @(posedge clk); #1;
    CE = 1'b0;
    repeat (gap - 1) begin
      @(posedge clk); #1;
    end
  endtask

  // Encodes msg[] with the given CE spacing and checks the emitted codeword.
  task automatic run_block(input string tag, input int gap, output int base);
    int rd, rp, v0, h0, n, sys_bad;
    base = outq.size();
    v0 = vcnt;
    h0 = hold_err;
    rd = 0;
    rp = 0;
    for (int k = 0; k < 188; k++) begin
      if (ready === 1'b1) rd++;
      send_byte(msg[k], gap);
    end
    for (int k = 0; k < 16; k++) begin
      if (ready === 1'b0) rp++;
      send_byte(8'hFF, gap);
    end
    n = 0;
    while (outq.size() < base + 204 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    check({tag, "_count"}, outq.size() - base, 204);
    if (outq.size() >= base + 204) begin
      sys_bad = 0;
      for (int k = 0; k < 188; k++) if (outq[base + k] !== msg[k]) sys_bad++;
      check({tag, "_systematic"}, sys_bad, 0);
      check({tag, "_syndrome"}, synd_or(base), 0);
      check({tag, "_valid_span"}, vcnt - v0, ceo_cyc[base + 203] - ceo_cyc[base] + 1);
    end
    check({tag, "_ready_data"}, rd, 188);
    check({tag, "_ready_parity"}, rp, 16);
    check({tag, "_valid_fall"}, Valid_out, 0);
    check({tag, "_hold"}, hold_err - h0, 0);
  endtask

  initial begin
    int base, nz, c0, gaps [3];
    gaps[0] = 3; gaps[1] = 8; gaps[2] = 2;
    reset = 1'b0;
    CE = 1'b0;
    input_byte = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out", Out_byte, 8'h00);
    check("rst_ceo", CEO, 0);
    check("rst_valid", Valid_out, 0);
    check("rst_ready", ready, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // All-zero message: all 204 outputs zero
    for (int k = 0; k < 188; k++) msg[k] = 8'h00;
    run_block("zero", 2, base);
    nz = 0;
    for (int k = 0; k < 204; k++) if (outq[base + k] !== 8'h00) nz++;
    check("zero_all_bytes", nz, 0);

    // Impulse in the last message byte: parity = g15..g0, g15 = g0 = 0x3B
    msg[187] = 8'h01;
    run_block("impulse", 2, base);
    check("impulse_g15", outq[base + 188], 8'h3B);
    check("impulse_g0", outq[base + 203], 8'h3B);

    // Random blocks with different CE spacing, last one back-to-back
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 188; k++) msg[k] = 8'($urandom_range(0, 255));
      run_block($sformatf("rand%0d", b), gaps[b], base);
    end

    // Reset after message byte 100 abandons the block
    for (int k = 0; k <= 100; k++) send_byte(8'($urandom_range(0, 255)), 2);
    reset = 1'b0;
    c0 = outq.size();
    send_byte(8'h5A, 2);
    @(negedge clk);
    check("midrst_out", Out_byte, 8'h00);
    check("midrst_ceo", CEO, 0);
    check("midrst_valid", Valid_out, 0);
    check("midrst_ready", ready, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("midrst_no_strobe", outq.size() - c0, 0);

    // Fresh block after reset must be a clean codeword
    for (int k = 0; k < 188; k++) msg[k] = 8'($urandom_range(0, 255));
    run_block("after_rst", 4, base);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
